// File: rtl/mul_seq.sv
// Shift-add 32x32->64 multiply sequencer driving the shared core ALU.
// Define MUL_SIGNED_EN to add signed_op and the FIX1/FIX2 sign correction.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
`ifdef MUL_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y
);

`ifdef MUL_SIGNED_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DONE = 3'd2,
    FIX1 = 3'd3,
    FIX2 = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
`endif

  state_t state, state_n;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mreg;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             last;

`ifdef MUL_SIGNED_EN
  logic [WIDTH-1:0] mreg_orig;
  logic             sgn;
`endif

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign prod_hi = acc;
  assign prod_lo = mreg;
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    alu_op  = 4'd0;
    alu_a   = '0;
    alu_b   = '0;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        alu_a = acc;
        alu_b = mreg[0] ? mcand : '0;
        if (last) begin
`ifdef MUL_SIGNED_EN
          state_n = sgn ? FIX1 : DONE;
`else
          state_n = DONE;
`endif
        end
      end
      DONE: begin
        state_n = IDLE;
      end
`ifdef MUL_SIGNED_EN
      // Two's-complement correction of the unsigned high word
      FIX1: begin
        alu_op  = 4'd1;
        alu_a   = acc;
        alu_b   = mcand[WIDTH-1] ? mreg_orig : '0;
        state_n = FIX2;
      end
      FIX2: begin
        alu_op  = 4'd1;
        alu_a   = acc;
        alu_b   = mreg_orig[WIDTH-1] ? mcand : '0;
        state_n = DONE;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  // ALU has no carry-out; an add wrapped iff the sum is below an operand
  assign carry = (alu_y < alu_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      mreg  <= '0;
      cnt   <= '0;
`ifdef MUL_SIGNED_EN
      mreg_orig <= '0;
      sgn       <= 1'b0;
`endif
    end else if (!kill) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= op_a;
            mreg  <= op_b;
            acc   <= '0;
            cnt   <= '0;
`ifdef MUL_SIGNED_EN
            mreg_orig <= op_b;
            sgn       <= signed_op;
`endif
          end
        end
        RUN: begin
          {acc, mreg} <= {carry, alu_y, mreg[WIDTH-1:1]};
          cnt         <= cnt + CNT_W'(1);
        end
`ifdef MUL_SIGNED_EN
        FIX1, FIX2: begin
          acc <= alu_y;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
